// File: rtl/regbank_pkg.sv
// Shared constants for the register-bank write-port arbiter: requester
// indices, link register index, default widths and a lowest-index picker.
package regbank_pkg;

  localparam int REQ_LINK = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_ALU  = 2;
  localparam int NUM_REQ  = 3;

  localparam logic [4:0] LINK_REG = 5'd1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // One-hot of the lowest set bit; zero when nothing is set.
  function automatic logic [NUM_REQ-1:0] pick_lowest(input logic [NUM_REQ-1:0] vec);
    logic [NUM_REQ-1:0] sel;
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regwrite_age_counter.sv
// Per-requester age counter: counts consecutive refused cycles while the
// request is pending and saturates at MAX_WAIT, where the requester is aged.
module regwrite_age_counter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_grant,
  output logic [WAIT_W-1:0] o_count,
  output logic              o_aged
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!i_valid || i_grant) begin
      r_count <= '0;
    end else if (r_count != MAX_CNT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_aged  = (r_count == MAX_CNT);

endmodule

// File: rtl/regwrite_arbiter.sv
// Shares the single register-bank write port between Link, Load and Alu with
// fixed priority plus aging; the winner is written one cycle after grant.
module regwrite_arbiter
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    Hold,
  input  logic [NUM_REQ-1:0]      ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqReg,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]      ReqReady,
  output logic                    RegWrite,
  output logic [ADDR_W-1:0]       WriteRegister,
  output logic [DATA_W-1:0]       WriteData
);

  logic [NUM_REQ-1:0] w_aged;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [ADDR_W-1:0]  w_sel_reg;
  logic [DATA_W-1:0]  w_sel_data;
  logic [WAIT_W-1:0]  w_unused_age_count [NUM_REQ];

  logic               r_write;
  logic [ADDR_W-1:0]  r_wreg;
  logic [DATA_W-1:0]  r_wdata;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
    regwrite_age_counter #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
    ) u_age (
      .clock   (clock),
      .reset   (reset),
      .i_valid (ReqValid[g]),
      .i_grant (w_grant[g]),
      .o_count (w_unused_age_count[g]),
      .o_aged  (w_aged[g])
    );
  end

  // Aged requesters pre-empt the fixed order; reset forces the grant low so
  // nothing can handshake while the bank port is being cleared.
  always_comb begin
    w_cand = ReqValid & w_aged;
    if (w_cand == '0) w_cand = ReqValid;
    w_grant = pick_lowest(w_cand);
    if (Hold || !reset) w_grant = '0;
  end

  assign ReqReady = w_grant;
  assign w_xfer   = |w_grant;

  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_reg  = ReqReg[i*ADDR_W +: ADDR_W];
        w_sel_data = ReqData[i*DATA_W +: DATA_W];
      end
    end
  end

  // R0 writes are consumed but never reach the bank.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_write <= w_xfer && (w_sel_reg != '0);
      if (w_xfer && (w_sel_reg != '0)) begin
        r_wreg  <= w_sel_reg;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign RegWrite      = r_write;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_wdata;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: reset, priority, aging, R0 drop,
// hold, same-destination collision and asynchronous reset mid-write.
module tb_regwrite_arbiter;
  import regbank_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic              clock;
  logic              reset;
  logic              Hold;
  logic [2:0]        ReqValid;
  logic [3*AW-1:0]   ReqReg;
  logic [3*DW-1:0]   ReqData;
  logic [2:0]        ReqReady;
  logic              RegWrite;
  logic [AW-1:0]     WriteRegister;
  logic [DW-1:0]     WriteData;

  int total = 0;
  int bad   = 0;

  regwrite_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_WAIT (4),
    .WAIT_W   (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .Hold          (Hold),
    .ReqValid      (ReqValid),
    .ReqReg        (ReqReg),
    .ReqData       (ReqData),
    .ReqReady      (ReqReady),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] r, input logic [DW-1:0] d);
    ReqReg[idx*AW +: AW]  = r;
    ReqData[idx*DW +: DW] = d;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [AW-1:0] r,
                          input logic [DW-1:0] d);
    check({tag, "_we"},   64'(RegWrite),      64'(we));
    check({tag, "_reg"},  64'(WriteRegister), 64'(r));
    check({tag, "_data"}, 64'(WriteData),     64'(d));
  endtask

  initial begin
    reset    = 1'b0;
    Hold     = 1'b0;
    ReqValid = 3'b111;
    ReqReg   = '0;
    ReqData  = '0;
    set_req(REQ_LINK, LINK_REG, 32'h1234);
    set_req(REQ_LOAD, 5'd2, 32'h5555);
    set_req(REQ_ALU,  5'd3, 32'h6666);

    // reset held with all requests pending
    #12;
    check("rst_ready", 64'(ReqReady), 64'(3'b000));
    check_wr("rst", 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    check("rst_ready2", 64'(ReqReady), 64'(3'b000));
    reset = 1'b1;
    #1;
    check("first_grant", 64'(ReqReady), 64'(3'b001));
    tick();
    ReqValid = 3'b000;
    #1;
    check_wr("first_wr", 1'b1, LINK_REG, 32'h1234);
    check("idle_ready", 64'(ReqReady), 64'(3'b000));
    tick();
    check_wr("idle_hold", 1'b0, LINK_REG, 32'h1234);

    // Load beats Alu, Alu follows next cycle
    set_req(REQ_LOAD, 5'd8, 32'h11);
    set_req(REQ_ALU,  5'd9, 32'h22);
    ReqValid = 3'b110;
    #1;
    check("prio_n", 64'(ReqReady), 64'(3'b010));
    tick();
    ReqValid = 3'b100;
    #1;
    check("prio_n1_ready", 64'(ReqReady), 64'(3'b100));
    check_wr("prio_n1", 1'b1, 5'd8, 32'h11);
    tick();
    ReqValid = 3'b000;
    #1;
    check_wr("prio_n2", 1'b1, 5'd9, 32'h22);
    tick();
    check("prio_n3_we", 64'(RegWrite), 64'(1'b0));

    // Alu waits behind a continuous Link stream until it ages
    set_req(REQ_ALU,  5'd5, 32'hAA);
    set_req(REQ_LOAD, 5'd4, 32'h44);
    for (int k = 1; k <= 5; k++) begin
      set_req(REQ_LINK, LINK_REG, DW'(k));
      ReqValid = {1'b1, (k >= 3), 1'b1};
      #1;
      check($sformatf("age_k%0d_ready", k), 64'(ReqReady), (k < 5) ? 64'(3'b001) : 64'(3'b100));
      if (k >= 2) check_wr($sformatf("age_k%0d", k), 1'b1, LINK_REG, DW'(k - 1));
      tick();
    end
    set_req(REQ_LINK, LINK_REG, 32'd6);
    ReqValid = 3'b011;
    #1;
    check("age_after_ready", 64'(ReqReady), 64'(3'b001));
    check_wr("age_alu_wr", 1'b1, 5'd5, 32'hAA);
    tick();
    ReqValid = 3'b000;
    #1;
    check_wr("age_link_wr", 1'b1, LINK_REG, 32'd6);
    tick();

    // R0 request is consumed but not written
    set_req(REQ_ALU, 5'd0, 32'hFF);
    ReqValid = 3'b100;
    #1;
    check("r0_ready", 64'(ReqReady), 64'(3'b100));
    tick();
    ReqValid = 3'b000;
    #1;
    check("r0_ready_next", 64'(ReqReady), 64'(3'b000));
    check_wr("r0_drop", 1'b0, LINK_REG, 32'd6);
    tick();

    // Hold freezes grants while the Load age climbs and saturates
    Hold = 1'b1;
    set_req(REQ_LOAD, 5'd3, 32'h7);
    ReqValid = 3'b010;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check($sformatf("hold_c%0d_ready", c), 64'(ReqReady), 64'(3'b000));
      check($sformatf("hold_c%0d_we", c), 64'(RegWrite), 64'(1'b0));
      if (c == 4) check("hold_age3", 64'(dut.g_age[1].u_age.o_count), 64'(3'd3));
      if (c == 6) check("hold_age_sat", 64'(dut.g_age[1].u_age.o_count), 64'(3'd4));
      tick();
    end
    Hold = 1'b0;
    #1;
    check("hold_release_ready", 64'(ReqReady), 64'(3'b010));
    tick();
    ReqValid = 3'b000;
    #1;
    check_wr("hold_wr", 1'b1, 5'd3, 32'h7);
    check("hold_age_clr", 64'(dut.g_age[1].u_age.o_count), 64'(3'd0));
    tick();

    // Same destination: Link first, Alu second, no merging
    set_req(REQ_LINK, 5'd1, 32'h100);
    set_req(REQ_ALU,  5'd1, 32'h200);
    ReqValid = 3'b101;
    #1;
    check("coll_n", 64'(ReqReady), 64'(3'b001));
    tick();
    ReqValid = 3'b100;
    #1;
    check("coll_n1_ready", 64'(ReqReady), 64'(3'b100));
    check_wr("coll_n1", 1'b1, 5'd1, 32'h100);
    tick();
    ReqValid = 3'b000;
    #1;
    check_wr("coll_n2", 1'b1, 5'd1, 32'h200);
    tick();
    check("coll_n3_we", 64'(RegWrite), 64'(1'b0));

    // Reset lands while a write is on the bank port
    set_req(REQ_LOAD, 5'd6, 32'h66);
    ReqValid = 3'b010;
    #1;
    check("mid_grant", 64'(ReqReady), 64'(3'b010));
    tick();
    ReqValid = 3'b000;
    check("mid_inflight_we", 64'(RegWrite), 64'(1'b1));
    reset = 1'b0;
    #1;
    check_wr("mid_rst", 1'b0, 5'd0, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("mid_no_replay", 64'(RegWrite), 64'(1'b0));
    tick();
    check_wr("mid_after", 1'b0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
